// File: rtl/end_screen_ctrl_pkg.sv
// Shared types for the end-of-game sequencer: state encoding and the overlay/game control bundle.
package end_screen_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_OVER    = 2'd1,
        ST_WIN     = 2'd2,
        ST_RESTART = 2'd3
    } end_state_e;

    typedef struct packed {
        logic game_over;
        logic victory;
        logic freeze;
        logic restart;
    } end_ctrl_out_t;

    // Outputs are a pure function of the state being entered, so they land on the same edge as the state.
    function automatic end_ctrl_out_t decode_outputs(end_state_e nxt, end_state_e cur, logic phase);
        end_ctrl_out_t o;
        o.game_over = (nxt == ST_OVER) && phase;
        o.victory   = (nxt == ST_WIN) && phase;
        o.freeze    = (nxt != ST_PLAY);
        o.restart   = (nxt == ST_RESTART) && (cur != ST_RESTART);
        return o;
    endfunction

endpackage

// File: rtl/end_screen_ctrl_button_debounce.sv
// Restart-button conditioning: 2-FF synchronizer, stability counter, and a one-cycle press on the debounced rise.
module end_screen_ctrl_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The debounced level flips on the last of DEBOUNCE_CYCLES consecutive differing samples; any agreement restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= db_d & ~db_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/end_screen_ctrl.sv
// End-of-game sequencer: latches game-over/victory, blinks the overlay flag, and issues restart after an arming delay.
module end_screen_ctrl
    import end_screen_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65000,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned ARM_FRAMES      = 60
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       game_over_req,
    input  logic       victory_req,
    input  logic       restart_btn,
    output logic       game_over_out,
    output logic       victory_out,
    output logic       freeze_out,
    output logic       restart_pulse,
    output logic [1:0] state_out
);

    localparam int unsigned FW = $clog2(ARM_FRAMES + 1);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    end_state_e    state_q;
    end_state_e    state_d;
    logic [FW-1:0] frame_q;
    logic [FW-1:0] frame_d;
    logic [BW-1:0] blink_q;
    logic [BW-1:0] blink_d;
    logic          phase_q;
    logic          phase_d;
    logic          vsync_q;
    logic          tick_c;
    logic          armed_c;
    logic          press_c;
    end_ctrl_out_t out_q;
    end_ctrl_out_t out_d;

    end_screen_ctrl_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (pclk),
        .rst_n  (rst),
        .btn_i  (restart_btn),
        .press_o(press_c)
    );

    assign tick_c  = vsync_in & ~vsync_q;
    assign armed_c = (frame_q == FW'(ARM_FRAMES));

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        blink_d = blink_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_PLAY: begin
                if (game_over_req) begin
                    state_d = ST_OVER;
                end else if (victory_req) begin
                    state_d = ST_WIN;
                end
                // Entry clear: a tick landing on the entry edge is deliberately lost.
                frame_d = '0;
                blink_d = '0;
                phase_d = 1'b1;
            end
            ST_OVER, ST_WIN: begin
                if (tick_c) begin
                    frame_d = armed_c ? frame_q : frame_q + FW'(1);
                    if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
                if (press_c && armed_c) begin
                    state_d = ST_RESTART;
                end
            end
            ST_RESTART: begin
                if (!game_over_req && !victory_req) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
        out_d = decode_outputs(state_d, state_q, phase_d);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PLAY;
            frame_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            vsync_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            vsync_q <= vsync_in;
            out_q   <= out_d;
        end
    end

    assign game_over_out = out_q.game_over;
    assign victory_out   = out_q.victory;
    assign freeze_out    = out_q.freeze;
    assign restart_pulse = out_q.restart;
    assign state_out     = state_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Directed bench for end_screen_ctrl with a scoreboard of expected output vectors.
module tb_end_screen_ctrl;

    logic       pclk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync_in = 1'b0;
    logic       game_over_req = 1'b0;
    logic       victory_req = 1'b0;
    logic       restart_btn = 1'b0;
    logic       game_over_out;
    logic       victory_out;
    logic       freeze_out;
    logic       restart_pulse;
    logic [1:0] state_out;

    int n_tests = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    int p0 = 0;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;
    exp_t exp_q[$];

    end_screen_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_FRAMES   (2),
        .ARM_FRAMES     (3)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .game_over_req(game_over_req),
        .victory_req  (victory_req),
        .restart_btn  (restart_btn),
        .game_over_out(game_over_out),
        .victory_out  (victory_out),
        .freeze_out   (freeze_out),
        .restart_pulse(restart_pulse),
        .state_out    (state_out)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (restart_pulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected vector layout: {state[1:0], game_over, victory, freeze, restart_pulse}
    task automatic push(input string tag, input int st, input bit go, input bit vic, input bit frz, input bit pls);
        exp_t e;
        e.tag = tag;
        e.v   = {2'(st), go, vic, frz, pls};
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [5:0] obs;
        obs = {state_out, game_over_out, victory_out, freeze_out, restart_pulse};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b required <entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %b required %b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic tick();
        vsync_in = 1'b1;
        step(1);
        vsync_in = 1'b0;
        step(1);
    endtask

    task automatic wait_state(input int target);
        int k;
        k = 0;
        while (state_out !== 2'(target) && k < 12) begin
            step(1);
            k++;
        end
    endtask

    task automatic release_btn();
        restart_btn = 1'b0;
        step(8);
    endtask

    task automatic enter_over(input string tag);
        game_over_req = 1'b1;
        push(tag, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        check();
        game_over_req = 1'b0;
    endtask

    // Assumes the end state is armed and both requests are low, so RESTART lasts one cycle.
    task automatic do_restart(input string tag);
        int base;
        base = pulse_cnt;
        restart_btn = 1'b1;
        push(tag, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_state(3);
        check();
        push({tag, "_play"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check();
        chk_int({tag, "_pulses"}, pulse_cnt - base, 1);
        release_btn();
    endtask

    initial begin
        // Reset state, including requests asserted while held in reset
        step(2);
        push("reset", 0, 0, 0, 0, 0);
        check();
        game_over_req = 1'b1;
        step(1);
        push("reset_req_high", 0, 0, 0, 0, 0);
        check();
        game_over_req = 1'b0;
        rst = 1'b1;
        step(2);
        push("play_idle", 0, 0, 0, 0, 0);
        check();

        // 1: game over blinks with a two-tick half period
        enter_over("t1_enter");
        push("t1_tick1", 1, 1, 0, 1, 0); tick(); check();
        push("t1_tick2", 1, 0, 0, 1, 0); tick(); check();
        push("t1_tick3", 1, 0, 0, 1, 0); tick(); check();
        push("t1_tick4", 1, 1, 0, 1, 0); tick(); check();
        do_restart("t1_restart");

        // 2: simultaneous requests resolve to game over
        game_over_req = 1'b1;
        victory_req = 1'b1;
        push("t2_both", 1, 1, 0, 1, 0);
        step(1);
        check();
        game_over_req = 1'b0;
        victory_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            push("t2_tick", 1, (i == 1), 0, 1, 0);
            tick();
            check();
        end
        do_restart("t2_restart");

        // 3: victory; unarmed press dropped, armed press restarts
        victory_req = 1'b1;
        push("t3_win", 2, 0, 1, 1, 0);
        step(1);
        check();
        push("t3_tick1", 2, 0, 1, 1, 0);
        tick();
        check();
        p0 = pulse_cnt;
        restart_btn = 1'b1;
        step(8);
        push("t3_unarmed_press", 2, 0, 1, 1, 0);
        check();
        chk_int("t3_no_pulse", pulse_cnt - p0, 0);
        release_btn();
        push("t3_tick2", 2, 0, 0, 1, 0); tick(); check();
        push("t3_tick3", 2, 0, 0, 1, 0); tick(); check();
        restart_btn = 1'b1;
        push("t3_restart", 3, 0, 0, 1, 1);
        wait_state(3);
        check();

        // 4: held victory request keeps RESTART without repeating the pulse
        for (int i = 0; i < 20; i++) begin
            push("t4_hold", 3, 0, 0, 1, 0);
            step(1);
            check();
        end
        chk_int("t4_one_pulse", pulse_cnt - p0, 1);
        victory_req = 1'b0;
        push("t4_play", 0, 0, 0, 0, 0);
        step(1);
        check();
        release_btn();

        // 5: bouncing button yields a single press only after a stable run
        enter_over("t5_enter");
        tick(); tick(); tick();
        p0 = pulse_cnt;
        for (int i = 0; i < 2; i++) begin
            restart_btn = 1'b1;
            step(2);
            restart_btn = 1'b0;
            step(2);
        end
        step(3);
        push("t5_bounce_ignored", 1, 0, 0, 1, 0);
        check();
        chk_int("t5_no_pulse_bounce", pulse_cnt - p0, 0);
        do_restart("t5_restart");

        // 6: reset mid-debounce clears state and the pending count
        enter_over("t6_enter");
        restart_btn = 1'b1;
        step(5);
        chk_int("t6_cnt_before", int'(dut.u_debounce.cnt_q), 3);
        p0 = pulse_cnt;
        rst = 1'b0;
        #1;
        push("t6_async_reset", 0, 0, 0, 0, 0);
        check();
        chk_int("t6_cnt_cleared", int'(dut.u_debounce.cnt_q), 0);
        step(2);
        rst = 1'b1;
        step(5);
        chk_int("t6_db_still_low", int'(dut.u_debounce.db_q), 0);
        step(1);
        chk_int("t6_db_high", int'(dut.u_debounce.db_q), 1);
        step(3);
        push("t6_play", 0, 0, 0, 0, 0);
        check();
        chk_int("t6_no_pulse", pulse_cnt - p0, 0);
        release_btn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
